// File: rtl/data_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder_if
// Brief    : Data-SRAM port bundle between the CPU data-memory unit and its
//            responder (request fields plus registered read data).
// Revision : 1.0  initial release
// ============================================================================
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Brief    : Word RAM with byte-lane writes plus a 16-byte MMIO window
//            (CNT / SCRATCH / LED). Read data is registered, one cycle latency.
//            Define DATA_SRAM_ERR_EN to capture the first unmapped access.
// Revision : 1.0  initial release
// ============================================================================
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h1FAF_0000,
    parameter int          LED_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_responder_if.slave  bus,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  bus_err,
    output logic [31:0]           bus_err_addr
);

    localparam int         c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [1:0] c_OFF_CNT  = 2'd0;
    localparam logic [1:0] c_OFF_SCR  = 2'd1;
    localparam logic [1:0] c_OFF_LED  = 2'd2;
    localparam logic [1:0] c_OFF_RSVD = 2'd3;

    logic [31:0]           r_mem [0:c_DEPTH-1];
    logic [31:0]           r_ram_q;
    logic [31:0]           r_reg_q;
    logic                  r_src_ram;
    logic [31:0]           r_cnt;
    logic [31:0]           r_scratch;
    logic [31:0]           r_led_reg;

    logic                  w_is_ram;
    logic                  w_is_mmio;
    logic                  w_access;
    logic                  w_is_write;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [1:0]            w_off;
    logic [31:0]           w_mask;
    logic [31:0]           w_mmio_rd;
    logic                  w_unused_bits;

    assign w_is_ram   = (bus.addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign w_is_mmio  = bus.addr[31:4] == MMIO_BASE[31:4];
    assign w_access   = bus.en && !rst;
    assign w_is_write = |bus.wen;
    assign w_word     = bus.addr[ADDR_WIDTH+1:2];
    assign w_off      = bus.addr[3:2];
    assign w_unused_bits = ^{bus.addr[1:0], r_led_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_mask[8*gi +: 8] = {8{bus.wen[gi]}};
        end
    endgenerate

    always_comb begin
        w_mmio_rd = 32'h0;
        if (w_is_mmio) begin
            case (w_off)
                c_OFF_CNT:  w_mmio_rd = r_cnt;
                c_OFF_SCR:  w_mmio_rd = r_scratch;
                c_OFF_LED:  w_mmio_rd = r_led_reg;
                c_OFF_RSVD: w_mmio_rd = 32'h0;
                default:    w_mmio_rd = 32'h0;
            endcase
        end
    end

    // Array kept free of reset so it maps onto block RAM; read-before-write.
    always_ff @(posedge clk) begin
        if (w_access && w_is_ram) begin
            r_ram_q <= r_mem[w_word];
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    r_mem[w_word][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 32'h0;
            r_scratch <= 32'h0;
            r_led_reg <= 32'h0;
            r_reg_q   <= 32'h0;
            r_src_ram <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (bus.en) begin
                r_src_ram <= w_is_ram;
                r_reg_q   <= w_mmio_rd;
                if (w_is_write && w_is_mmio) begin
                    case (w_off)
                        c_OFF_SCR: r_scratch <= (r_scratch & ~w_mask) | (bus.wdata & w_mask);
                        c_OFF_LED: r_led_reg <= (r_led_reg & ~w_mask) | (bus.wdata & w_mask);
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Source select is registered, so rdata holds across idle cycles.
    assign bus.rdata = r_src_ram ? r_ram_q : r_reg_q;
    assign led       = r_led_reg[LED_WIDTH-1:0];

`ifdef DATA_SRAM_ERR_EN
    logic        r_bus_err;
    logic [31:0] r_bus_err_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err      <= 1'b0;
            r_bus_err_addr <= 32'h0;
        end else if (bus.en && !w_is_ram && !w_is_mmio && !r_bus_err) begin
            r_bus_err      <= 1'b1;
            r_bus_err_addr <= bus.addr;
        end
    end

    assign bus_err      = r_bus_err;
    assign bus_err_addr = r_bus_err_addr;
`else
    assign bus_err      = 1'b0;
    assign bus_err_addr = 32'h0;
`endif

endmodule
`default_nettype wire
